// File: rtl/p05_uart_tx_pkg.sv
// Shared definitions for the p05 UART transmitter: FSM state encoding and
// frame-length helper.
package p05_uart_tx_pkg;

    // Transmitter FSM states, 3-bit encoding (IDLE is all-zero so reset is obvious)
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } p05_state_e;

    // Number of data bits in every frame
    localparam int unsigned DATA_BITS = 8;

    // Clock cycles from the first start-bit cycle to the last stop-bit cycle
    function automatic int unsigned frame_cycles(input int unsigned clks_per_bit,
                                                 input int unsigned parity_en,
                                                 input int unsigned stop_bits);
        return (1 + DATA_BITS + parity_en + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/p05_uart_tx_baud_tick.sv
// Bit-period timer: emits a one-cycle tick on the last cycle of every
// CLKS_PER_BIT-cycle bit period. While clr is high the counter is held at 0
// and no tick is produced, so the first period after clr drops is full length.
module p05_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 16,
    localparam int unsigned CW = $clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Count cycles within a bit period, wrapping to 0 at the bit boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/p05_uart_tx.sv
// UART transmitter: accepts a byte with a valid/ready handshake and sends a
// start bit, 8 data bits LSB first, optional even parity, and 1 or 2 stop bits.
//
// Handshake: a byte is accepted on a rising edge where valid=1 and ready=1.
// ready is a pure function of the state register (high only in IDLE) and never
// looks at valid; valid and data_in are ignored whenever ready=0.
module p05_uart_tx
    import p05_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    output logic       txd,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    p05_state_e state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic       par_q, par_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       txd_q, txd_d;
    logic       tick;
    logic       accept;

    // Timer runs only while a frame is on the line
    p05_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (ready),
        .tick (tick)
    );

    assign ready     = (state_q == ST_IDLE);
    assign busy      = !ready;
    assign accept    = valid && ready;
    assign txd       = txd_q;
    assign state_dbg = state_q;

    // State and datapath registers; reset aborts any frame and idles the line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
        end
    end

    // Next-state, shift register and line-level decode
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        bit_idx_d = bit_idx_q;
        txd_d     = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_START;
                    shreg_d   = data_in;
                    par_d     = ^data_in;
                    bit_idx_d = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_DATA) begin
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_idx_q == LAST_STOP) begin
                        state_d   = ST_IDLE;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line level is registered from the state being entered, so txd
        // changes on the same edge as the state register.
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shreg_d[0];
            ST_PARITY: txd_d = par_d;
            default:   txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_p05_uart_tx.sv
// Testbench for p05_uart_tx: three instances with different parameter sets,
// directed frames plus random bursts, checked cycle by cycle against a
// bit-list model of the serial frame.
module tb_p05_uart_tx;
    import p05_uart_tx_pkg::*;

    localparam int NDUT = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n     [NDUT];
    logic [7:0] din       [NDUT];
    logic       valid     [NDUT];
    logic       ready     [NDUT];
    logic       txd       [NDUT];
    logic       busy      [NDUT];
    logic [2:0] state_dbg [NDUT];

    // d0: 4 clk/bit, no parity, 1 stop
    p05_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .data_in(din[0]), .valid(valid[0]),
        .ready(ready[0]), .txd(txd[0]), .busy(busy[0]), .state_dbg(state_dbg[0]));
    // d1: 4 clk/bit, even parity, 1 stop
    p05_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .data_in(din[1]), .valid(valid[1]),
        .ready(ready[1]), .txd(txd[1]), .busy(busy[1]), .state_dbg(state_dbg[1]));
    // d2: 2 clk/bit, no parity, 2 stop
    p05_uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n[2]), .data_in(din[2]), .valid(valid[2]),
        .ready(ready[2]), .txd(txd[2]), .busy(busy[2]), .state_dbg(state_dbg[2]));

    function automatic int cpb_of(input int d);
        case (d)
            0: return 4;
            1: return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int par_of(input int d);
        return (d == 1) ? 1 : 0;
    endfunction

    function automatic int stop_of(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [0:0] exp_q[$];
    logic [7:0] byte_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Expected line level for every cycle of one frame
    task automatic build_expected(input int d, input logic [7:0] b);
        logic bits[$];
        int   ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            bits.push_back(b[i]);
            ones += int'(b[i]);
        end
        if (par_of(d) != 0) bits.push_back((ones % 2) == 1);
        for (int s = 0; s < stop_of(d); s++) bits.push_back(1'b1);
        exp_q.delete();
        foreach (bits[i]) begin
            for (int c = 0; c < cpb_of(d); c++) exp_q.push_back(bits[i]);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge. Sends every byte of byte_q with valid held high
    // (next byte presented during the current frame), then drops valid and
    // puts mid_data on data_in for the last frame.
    task automatic tx_burst(input int d, input logic [7:0] mid_data);
        int n = byte_q.size();
        int len;
        din[d]   = byte_q[0];
        valid[d] = 1'b1;
        for (int k = 0; k < n; k++) begin
            check($sformatf("d%0d ready_before_frame%0d", d, k), 32'(ready[d]), 1);
            check($sformatf("d%0d busy_before_frame%0d", d, k), 32'(busy[d]), 0);
            build_expected(d, byte_q[k]);
            len = exp_q.size();
            @(negedge clk);
            if (k + 1 < n) begin
                din[d] = byte_q[k + 1];
            end else begin
                valid[d] = 1'b0;
                din[d]   = mid_data;
            end
            for (int c = 0; c < len; c++) begin
                check($sformatf("d%0d byte%02h txd cyc%0d", d, byte_q[k], c), 32'(txd[d]), 32'(exp_q.pop_front()));
                check($sformatf("d%0d byte%02h busy cyc%0d", d, byte_q[k], c), 32'(busy[d]), 1);
                @(negedge clk);
            end
        end
        check($sformatf("d%0d ready_after_burst", d), 32'(ready[d]), 1);
        check($sformatf("d%0d txd_idle_after_burst", d), 32'(txd[d]), 1);
    endtask

    // Starts a frame, then pulses reset during data bit 3
    task automatic reset_mid_frame(input int d, input logic [7:0] b);
        din[d]   = b;
        valid[d] = 1'b1;
        @(negedge clk);
        valid[d] = 1'b0;
        repeat (cpb_of(d) * 4 + 1) @(negedge clk);
        check($sformatf("d%0d bit3_before_reset", d), 32'(txd[d]), 32'(b[3]));
        #1 rst_n[d] = 1'b0;
        #1;
        check($sformatf("d%0d txd_async_reset", d), 32'(txd[d]), 1);
        check($sformatf("d%0d ready_async_reset", d), 32'(ready[d]), 1);
        check($sformatf("d%0d busy_async_reset", d), 32'(busy[d]), 0);
        check($sformatf("d%0d state_async_reset", d), 32'(state_dbg[d]), 32'(ST_IDLE));
        @(negedge clk);
        @(negedge clk);
        rst_n[d] = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d;
        int n;
        for (int i = 0; i < NDUT; i++) begin
            rst_n[i] = 1'b0;
            valid[i] = 1'b0;
            din[i]   = 8'h00;
        end
        #12;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("d%0d reset_txd", i), 32'(txd[i]), 1);
            check($sformatf("d%0d reset_ready", i), 32'(ready[i]), 1);
            check($sformatf("d%0d reset_busy", i), 32'(busy[i]), 0);
            check($sformatf("d%0d reset_state", i), 32'(state_dbg[i]), 32'(ST_IDLE));
        end
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) rst_n[i] = 1'b1;

        // 0xA5 without parity, accepted on the first edge after reset release
        byte_q = '{8'hA5};
        tx_burst(0, 8'h00);
        // Parity frames
        byte_q = '{8'h07};
        tx_burst(1, 8'h12);
        byte_q = '{8'hA5};
        tx_burst(1, 8'h34);
        // Back-to-back frames with valid held high
        byte_q = '{8'h55, 8'hAA};
        tx_burst(0, 8'h00);
        // data_in changed mid-frame
        byte_q = '{8'h3C};
        tx_burst(0, 8'hFF);
        // Reset during data bit 3, then a clean frame on the first edge after release
        reset_mid_frame(0, 8'h5A);
        byte_q = '{8'h81};
        tx_burst(0, 8'($urandom));
        // Two stop bits at 2 clk/bit
        byte_q = '{8'h00};
        tx_burst(2, 8'hFF);

        // Random bursts on random instances
        repeat (24) begin
            d = $urandom_range(0, NDUT - 1);
            n = $urandom_range(1, 3);
            byte_q.delete();
            repeat (n) byte_q.push_back(8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            tx_burst(d, 8'($urandom));
        end

        // Random mid-frame reset followed by a random frame
        d = $urandom_range(0, NDUT - 1);
        reset_mid_frame(d, 8'($urandom));
        byte_q = '{8'($urandom)};
        tx_burst(d, 8'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
